// File: rtl/uart_frame_rx.sv
// uart_frame_rx: deframes UART byte strobes into sync-headed, length-prefixed,
// checksummed frames. A verified frame is held in an internal buffer for the
// host, which reads it by address and releases it with frame_ack. Delivery,
// error and drop statistics are kept as wrapping 16-bit counters.
module uart_frame_rx #(
  parameter logic [7:0]  SYNC0   = 8'hEB,
  parameter logic [7:0]  SYNC1   = 8'h90,
  parameter int unsigned MAX_LEN = 64,
  parameter logic [15:0] TIMEOUT = 16'd50000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  uart_rx_data,
  input  logic        uart_rx_data_ready,
  input  logic        uart_rx_err,
  output logic        frame_ready,
  output logic [7:0]  frame_len,
  input  logic        frame_ack,
  input  logic [7:0]  rd_addr,
  output logic [7:0]  rd_data,
  output logic [15:0] frame_ok_cnt,
  output logic [15:0] frame_err_cnt,
  output logic [15:0] frame_drop_cnt
);

  localparam int unsigned AW         = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam logic [7:0]  MAX_LEN_B  = 8'(MAX_LEN);
  localparam logic [15:0] TIMEOUT_M1 = TIMEOUT - 16'd1;

  typedef enum logic [2:0] {
    ST_HUNT0   = 3'd0,
    ST_HUNT1   = 3'd1,
    ST_LEN     = 3'd2,
    ST_PAYLOAD = 3'd3,
    ST_CSUM    = 3'd4
  } state_e;

  // Running 8-bit additive checksum (modulo 256).
  function automatic logic [7:0] csum_add(input logic [7:0] acc, input logic [7:0] b);
    return acc + b;
  endfunction

  state_e      state_q, state_d;
  logic [7:0]  len_q, len_d;
  logic [7:0]  sum_q, sum_d;
  logic [7:0]  idx_q, idx_d;
  logic        discard_q, discard_d;
  logic [15:0] gap_q, gap_d;
  logic        frame_ready_q, frame_ready_d;
  logic [7:0]  frame_len_q, frame_len_d;
  logic [15:0] ok_cnt_q, err_cnt_q, drop_cnt_q;
  logic [7:0]  rd_data_q;
  logic        ok_inc_s, err_inc_s, drop_inc_s, buf_we_s;

  logic [7:0]  buf_mem [0:MAX_LEN-1];

  // Parser next-state, gap timer, hold/release of the frame and counter strobes.
  always_comb begin
    state_d    = state_q;
    len_d      = len_q;
    sum_d      = sum_q;
    idx_d      = idx_q;
    discard_d  = discard_q;
    gap_d      = gap_q;
    frame_len_d = frame_len_q;
    ok_inc_s   = 1'b0;
    err_inc_s  = 1'b0;
    drop_inc_s = 1'b0;
    buf_we_s   = 1'b0;

    // The host release only matters while a frame is actually held.
    if (frame_ready_q && frame_ack) begin
      frame_ready_d = 1'b0;
    end else begin
      frame_ready_d = frame_ready_q;
    end

    if (uart_rx_data_ready) begin
      gap_d = 16'd0;
      case (state_q)
        ST_HUNT0: begin
          if (!uart_rx_err && (uart_rx_data == SYNC0)) begin
            state_d = ST_HUNT1;
          end else begin
            state_d = ST_HUNT0;
          end
        end
        ST_HUNT1: begin
          if (uart_rx_err) begin
            state_d = ST_HUNT0;
          end else if (uart_rx_data == SYNC1) begin
            state_d = ST_LEN;
          end else if (uart_rx_data == SYNC0) begin
            state_d = ST_HUNT1;
          end else begin
            state_d = ST_HUNT0;
          end
        end
        ST_LEN: begin
          if (uart_rx_err || (uart_rx_data == 8'd0) || (uart_rx_data > MAX_LEN_B)) begin
            err_inc_s = 1'b1;
            state_d   = ST_HUNT0;
          end else begin
            len_d     = uart_rx_data;
            sum_d     = uart_rx_data;
            idx_d     = 8'd0;
            // A held frame must not be overwritten: remember to drop this one.
            discard_d = frame_ready_q;
            state_d   = ST_PAYLOAD;
          end
        end
        ST_PAYLOAD: begin
          if (uart_rx_err) begin
            err_inc_s = 1'b1;
            state_d   = ST_HUNT0;
          end else begin
            sum_d    = csum_add(sum_q, uart_rx_data);
            buf_we_s = !discard_q;
            idx_d    = idx_q + 8'd1;
            if (idx_q == (len_q - 8'd1)) begin
              state_d = ST_CSUM;
            end else begin
              state_d = ST_PAYLOAD;
            end
          end
        end
        ST_CSUM: begin
          state_d = ST_HUNT0;
          if (uart_rx_err) begin
            err_inc_s = 1'b1;
          end else if (uart_rx_data == sum_q) begin
            if (discard_q) begin
              drop_inc_s = 1'b1;
            end else begin
              frame_ready_d = 1'b1;
              frame_len_d   = len_q;
              ok_inc_s      = 1'b1;
            end
          end else begin
            err_inc_s = 1'b1;
          end
        end
        default: begin
          state_d = ST_HUNT0;
        end
      endcase
    end else if (state_q != ST_HUNT0) begin
      if (gap_q == TIMEOUT_M1) begin
        // Inter-byte gap expired: abandon the frame; only a started frame counts.
        gap_d     = 16'd0;
        state_d   = ST_HUNT0;
        err_inc_s = (state_q != ST_HUNT1);
      end else begin
        gap_d = gap_q + 16'd1;
      end
    end else begin
      gap_d = 16'd0;
    end
  end

  // Parser, held-frame and statistics registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_HUNT0;
      len_q         <= 8'd0;
      sum_q         <= 8'd0;
      idx_q         <= 8'd0;
      discard_q     <= 1'b0;
      gap_q         <= 16'd0;
      frame_ready_q <= 1'b0;
      frame_len_q   <= 8'd0;
      ok_cnt_q      <= 16'd0;
      err_cnt_q     <= 16'd0;
      drop_cnt_q    <= 16'd0;
    end else begin
      state_q       <= state_d;
      len_q         <= len_d;
      sum_q         <= sum_d;
      idx_q         <= idx_d;
      discard_q     <= discard_d;
      gap_q         <= gap_d;
      frame_ready_q <= frame_ready_d;
      frame_len_q   <= frame_len_d;
      ok_cnt_q      <= ok_cnt_q + {15'd0, ok_inc_s};
      err_cnt_q     <= err_cnt_q + {15'd0, err_inc_s};
      drop_cnt_q    <= drop_cnt_q + {15'd0, drop_inc_s};
    end
  end

  // Payload buffer write port; index is always below the accepted length.
  always_ff @(posedge clk) begin
    if (buf_we_s) begin
      buf_mem[idx_q[AW-1:0]] <= uart_rx_data;
    end
  end

  // Registered buffer read; out-of-range addresses return zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data_q <= 8'd0;
    end else if (rd_addr < MAX_LEN_B) begin
      rd_data_q <= buf_mem[rd_addr[AW-1:0]];
    end else begin
      rd_data_q <= 8'd0;
    end
  end

  assign frame_ready    = frame_ready_q;
  assign frame_len      = frame_len_q;
  assign rd_data        = rd_data_q;
  assign frame_ok_cnt   = ok_cnt_q;
  assign frame_err_cnt  = err_cnt_q;
  assign frame_drop_cnt = drop_cnt_q;

endmodule

// File: tb/tb_uart_frame_rx.sv
// Testbench for uart_frame_rx: frames are built in the bench, expected
// deliveries go into a scoreboard queue, and are popped and compared when
// the DUT raises frame_ready.
module tb_uart_frame_rx;

  localparam int         TO = 100;
  localparam logic [7:0] S0 = 8'hEB;
  localparam logic [7:0] S1 = 8'h90;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  uart_rx_data = 8'd0;
  logic        uart_rx_data_ready = 1'b0;
  logic        uart_rx_err = 1'b0;
  logic        frame_ready;
  logic [7:0]  frame_len;
  logic        frame_ack = 1'b0;
  logic [7:0]  rd_addr = 8'd0;
  logic [7:0]  rd_data;
  logic [15:0] frame_ok_cnt, frame_err_cnt, frame_drop_cnt;

  always #5 clk = ~clk;

  uart_frame_rx #(
    .SYNC0(S0), .SYNC1(S1), .MAX_LEN(64), .TIMEOUT(16'(TO))
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .uart_rx_data(uart_rx_data), .uart_rx_data_ready(uart_rx_data_ready),
    .uart_rx_err(uart_rx_err),
    .frame_ready(frame_ready), .frame_len(frame_len), .frame_ack(frame_ack),
    .rd_addr(rd_addr), .rd_data(rd_data),
    .frame_ok_cnt(frame_ok_cnt), .frame_err_cnt(frame_err_cnt),
    .frame_drop_cnt(frame_drop_cnt)
  );

  int total = 0;
  int bad = 0;
  int exp_ok = 0, exp_err = 0, exp_drop = 0;
  logic [7:0] exp_len_q[$];
  logic [7:0] exp_dat_q[$];
  logic [7:0] tx_q[$];
  logic [7:0] pl [0:63];

  // One strobed byte followed by one idle clk; optional error flag and ack.
  task automatic send_byte(input logic [7:0] b, input logic e, input logic a);
    @(negedge clk);
    uart_rx_data = b; uart_rx_data_ready = 1'b1; uart_rx_err = e; frame_ack = a;
    @(negedge clk);
    uart_rx_data_ready = 1'b0; uart_rx_err = 1'b0; frame_ack = 1'b0;
  endtask

  // Append a frame built from pl[0..n-1] to tx_q; optionally expect delivery.
  task automatic push_frame(input int n, input bit corrupt, input bit deliver);
    logic [7:0] s;
    s = 8'(n);
    tx_q.push_back(S0);
    tx_q.push_back(S1);
    tx_q.push_back(8'(n));
    for (int i = 0; i < n; i++) begin
      tx_q.push_back(pl[i]);
      s = s + pl[i];
      if (deliver) exp_dat_q.push_back(pl[i]);
    end
    if (deliver) exp_len_q.push_back(8'(n));
    tx_q.push_back(corrupt ? (s ^ 8'h01) : s);
  endtask

  // Send tx_q, either with one idle clk between bytes or strobing every clk.
  task automatic flush_tx(input bit b2b);
    while (tx_q.size() > 0) begin
      @(negedge clk);
      uart_rx_data = tx_q.pop_front(); uart_rx_data_ready = 1'b1; uart_rx_err = 1'b0;
      if (!b2b) begin
        @(negedge clk);
        uart_rx_data_ready = 1'b0;
      end
    end
    if (b2b) begin
      @(negedge clk);
      uart_rx_data_ready = 1'b0;
    end
  endtask

  // Scoreboard consumer: compare the held frame against the oldest expectation.
  task automatic check_frame();
    int n;
    logic [7:0] e;
    total++;
    if (frame_ready !== 1'b1) begin
      bad++; $display("FAIL frame_ready: got %b want 1", frame_ready);
    end
    total++;
    if (exp_len_q.size() == 0) begin
      bad++; $display("FAIL scoreboard: got empty queue want pending frame");
    end else begin
      n = int'(exp_len_q.pop_front());
      total++;
      if (frame_len !== 8'(n)) begin
        bad++; $display("FAIL frame_len: got %0d want %0d", frame_len, n);
      end
      for (int i = 0; i < n; i++) begin
        @(negedge clk); rd_addr = 8'(i);
        @(negedge clk);
        e = exp_dat_q.pop_front();
        total++;
        if (rd_data !== e) begin
          bad++; $display("FAIL rd_data[%0d]: got %h want %h", i, rd_data, e);
        end
      end
    end
  endtask

  // Release the held frame and confirm frame_ready drops a clk later.
  task automatic do_ack();
    @(negedge clk); frame_ack = 1'b1;
    @(negedge clk); frame_ack = 1'b0;
    total++;
    if (frame_ready !== 1'b0) begin
      bad++; $display("FAIL ack_clear: got %b want 0", frame_ready);
    end
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    total++; if (frame_ready !== 1'b0) begin bad++; $display("FAIL rst_ready: got %b want 0", frame_ready); end
    total++; if (frame_len !== 8'd0) begin bad++; $display("FAIL rst_len: got %h want 00", frame_len); end
    total++; if (rd_data !== 8'd0) begin bad++; $display("FAIL rst_rd_data: got %h want 00", rd_data); end
    total++; if (frame_ok_cnt !== 16'd0) begin bad++; $display("FAIL rst_ok: got %0d want 0", frame_ok_cnt); end
    total++; if (frame_err_cnt !== 16'd0) begin bad++; $display("FAIL rst_err: got %0d want 0", frame_err_cnt); end
    total++; if (frame_drop_cnt !== 16'd0) begin bad++; $display("FAIL rst_drop: got %0d want 0", frame_drop_cnt); end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_good_frame();
    pl[0] = 8'h11; pl[1] = 8'h22; pl[2] = 8'h33;
    push_frame(3, 1'b0, 1'b1);
    flush_tx(1'b0);
    exp_ok++;
    check_frame();
    total++; if (frame_ok_cnt !== 16'(exp_ok)) begin bad++; $display("FAIL good_ok: got %0d want %0d", frame_ok_cnt, exp_ok); end
    do_ack();
  endtask

  task automatic test_bad_csum();
    pl[0] = 8'h11; pl[1] = 8'h22; pl[2] = 8'h33;
    push_frame(3, 1'b1, 1'b0);
    flush_tx(1'b0);
    exp_err++;
    total++; if (frame_ready !== 1'b0) begin bad++; $display("FAIL csum_ready: got %b want 0", frame_ready); end
    total++; if (frame_err_cnt !== 16'(exp_err)) begin bad++; $display("FAIL csum_err: got %0d want %0d", frame_err_cnt, exp_err); end
    push_frame(3, 1'b0, 1'b1);
    flush_tx(1'b0);
    exp_ok++;
    check_frame();
    do_ack();
  endtask

  task automatic test_noise_resync();
    tx_q.push_back(8'h00);
    tx_q.push_back(S0);
    pl[0] = 8'h5A;
    push_frame(1, 1'b0, 1'b1);
    flush_tx(1'b0);
    exp_ok++;
    check_frame();
    total++; if (frame_err_cnt !== 16'(exp_err)) begin bad++; $display("FAIL noise_err: got %0d want %0d", frame_err_cnt, exp_err); end
    total++; if (frame_ok_cnt !== 16'(exp_ok)) begin bad++; $display("FAIL noise_ok: got %0d want %0d", frame_ok_cnt, exp_ok); end
    do_ack();
  endtask

  task automatic test_bad_len();
    tx_q.push_back(S0); tx_q.push_back(S1); tx_q.push_back(8'd0);
    tx_q.push_back(S0); tx_q.push_back(S1); tx_q.push_back(8'd65);
    flush_tx(1'b0);
    exp_err += 2;
    total++; if (frame_err_cnt !== 16'(exp_err)) begin bad++; $display("FAIL len_err: got %0d want %0d", frame_err_cnt, exp_err); end
    total++; if (frame_ready !== 1'b0) begin bad++; $display("FAIL len_ready: got %b want 0", frame_ready); end
    pl[0] = 8'h3C;
    push_frame(1, 1'b0, 1'b1);
    flush_tx(1'b0);
    exp_ok++;
    check_frame();
    do_ack();
  endtask

  task automatic test_max_len();
    for (int i = 0; i < 64; i++) pl[i] = 8'(i * 3 + 7);
    push_frame(64, 1'b0, 1'b1);
    flush_tx(1'b0);
    exp_ok++;
    check_frame();
    do_ack();
  endtask

  task automatic test_drop();
    pl[0] = 8'h11; pl[1] = 8'h22; pl[2] = 8'h33;
    push_frame(3, 1'b0, 1'b1);
    flush_tx(1'b0);
    exp_ok++;
    pl[0] = 8'hAA;
    push_frame(1, 1'b0, 1'b0);
    flush_tx(1'b0);
    exp_drop++;
    total++; if (frame_drop_cnt !== 16'(exp_drop)) begin bad++; $display("FAIL drop_cnt: got %0d want %0d", frame_drop_cnt, exp_drop); end
    total++; if (frame_ok_cnt !== 16'(exp_ok)) begin bad++; $display("FAIL drop_ok: got %0d want %0d", frame_ok_cnt, exp_ok); end
    check_frame();
    do_ack();
    for (int i = 0; i < 5; i++) pl[i] = 8'(8'hC0 + i);
    push_frame(5, 1'b0, 1'b1);
    flush_tx(1'b0);
    exp_ok++;
    check_frame();
    do_ack();
  endtask

  task automatic test_ack_race();
    pl[0] = 8'h44; pl[1] = 8'h55;
    push_frame(2, 1'b0, 1'b1);
    flush_tx(1'b0);
    exp_ok++;
    check_frame();
    send_byte(S0, 1'b0, 1'b0);
    send_byte(S1, 1'b0, 1'b0);
    send_byte(8'd1, 1'b0, 1'b1);
    total++; if (frame_ready !== 1'b0) begin bad++; $display("FAIL race_ack: got %b want 0", frame_ready); end
    send_byte(8'hAA, 1'b0, 1'b0);
    send_byte(8'hAB, 1'b0, 1'b0);
    exp_drop++;
    total++; if (frame_drop_cnt !== 16'(exp_drop)) begin bad++; $display("FAIL race_drop: got %0d want %0d", frame_drop_cnt, exp_drop); end
    total++; if (frame_ready !== 1'b0) begin bad++; $display("FAIL race_ready: got %b want 0", frame_ready); end
  endtask

  task automatic test_uart_err();
    send_byte(S0, 1'b0, 1'b0);
    send_byte(S1, 1'b0, 1'b0);
    send_byte(8'd3, 1'b0, 1'b0);
    send_byte(8'h11, 1'b0, 1'b0);
    send_byte(8'h22, 1'b1, 1'b0);
    send_byte(8'h33, 1'b0, 1'b0);
    send_byte(8'h69, 1'b0, 1'b0);
    exp_err++;
    total++; if (frame_err_cnt !== 16'(exp_err)) begin bad++; $display("FAIL uerr_err: got %0d want %0d", frame_err_cnt, exp_err); end
    total++; if (frame_ready !== 1'b0) begin bad++; $display("FAIL uerr_ready: got %b want 0", frame_ready); end
  endtask

  task automatic test_timeout();
    logic [7:0] b;
    send_byte(S0, 1'b0, 1'b0);
    send_byte(S1, 1'b0, 1'b0);
    send_byte(8'd3, 1'b0, 1'b0);
    repeat (TO + 5) @(negedge clk);
    exp_err++;
    total++; if (frame_err_cnt !== 16'(exp_err)) begin bad++; $display("FAIL to_err: got %0d want %0d", frame_err_cnt, exp_err); end
    send_byte(8'h11, 1'b0, 1'b0);
    send_byte(8'h22, 1'b0, 1'b0);
    send_byte(8'h33, 1'b0, 1'b0);
    send_byte(8'h69, 1'b0, 1'b0);
    total++; if (frame_ready !== 1'b0) begin bad++; $display("FAIL to_ready: got %b want 0", frame_ready); end
    // Timeout while waiting for the second sync byte is silent.
    send_byte(S0, 1'b0, 1'b0);
    repeat (TO + 5) @(negedge clk);
    send_byte(S1, 1'b0, 1'b0);
    send_byte(8'd1, 1'b0, 1'b0);
    send_byte(8'hAA, 1'b0, 1'b0);
    send_byte(8'hAB, 1'b0, 1'b0);
    total++; if (frame_err_cnt !== 16'(exp_err)) begin bad++; $display("FAIL h1_to_err: got %0d want %0d", frame_err_cnt, exp_err); end
    total++; if (frame_ready !== 1'b0) begin bad++; $display("FAIL h1_to_ready: got %b want 0", frame_ready); end
    // Long gaps just under the limit still deliver.
    pl[0] = 8'h77;
    push_frame(1, 1'b0, 1'b1);
    while (tx_q.size() > 0) begin
      b = tx_q.pop_front();
      send_byte(b, 1'b0, 1'b0);
      repeat (TO - 20) @(negedge clk);
    end
    exp_ok++;
    check_frame();
    do_ack();
  endtask

  task automatic test_back_to_back();
    pl[0] = 8'h01; pl[1] = 8'h02; pl[2] = 8'h03;
    push_frame(3, 1'b1, 1'b0);
    pl[0] = 8'hF0; pl[1] = 8'h0F;
    push_frame(2, 1'b0, 1'b1);
    flush_tx(1'b1);
    exp_err++; exp_ok++;
    total++; if (frame_err_cnt !== 16'(exp_err)) begin bad++; $display("FAIL b2b_err: got %0d want %0d", frame_err_cnt, exp_err); end
    total++; if (frame_ok_cnt !== 16'(exp_ok)) begin bad++; $display("FAIL b2b_ok: got %0d want %0d", frame_ok_cnt, exp_ok); end
    check_frame();
    do_ack();
  endtask

  task automatic test_reset_mid_frame();
    pl[0] = 8'h12;
    push_frame(1, 1'b0, 1'b1);
    flush_tx(1'b0);
    send_byte(S0, 1'b0, 1'b0);
    send_byte(S1, 1'b0, 1'b0);
    send_byte(8'd2, 1'b0, 1'b0);
    send_byte(8'h11, 1'b0, 1'b0);
    @(negedge clk); rst_n = 1'b0;
    @(negedge clk);
    total++; if (frame_ready !== 1'b0) begin bad++; $display("FAIL mid_rst_ready: got %b want 0", frame_ready); end
    total++; if (frame_len !== 8'd0) begin bad++; $display("FAIL mid_rst_len: got %h want 00", frame_len); end
    total++; if (rd_data !== 8'd0) begin bad++; $display("FAIL mid_rst_rd: got %h want 00", rd_data); end
    total++; if (frame_ok_cnt !== 16'd0) begin bad++; $display("FAIL mid_rst_ok: got %0d want 0", frame_ok_cnt); end
    total++; if (frame_err_cnt !== 16'd0) begin bad++; $display("FAIL mid_rst_err: got %0d want 0", frame_err_cnt); end
    total++; if (frame_drop_cnt !== 16'd0) begin bad++; $display("FAIL mid_rst_drop: got %0d want 0", frame_drop_cnt); end
    exp_ok = 0; exp_err = 0; exp_drop = 0;
    exp_len_q.delete();
    exp_dat_q.delete();
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
    pl[0] = 8'h99; pl[1] = 8'h66;
    push_frame(2, 1'b0, 1'b1);
    flush_tx(1'b0);
    exp_ok++;
    check_frame();
    total++; if (frame_ok_cnt !== 16'(exp_ok)) begin bad++; $display("FAIL post_rst_ok: got %0d want %0d", frame_ok_cnt, exp_ok); end
    do_ack();
  endtask

  initial begin
    test_reset();
    test_good_frame();
    test_bad_csum();
    test_noise_resync();
    test_bad_len();
    test_max_len();
    test_drop();
    test_ack_race();
    test_uart_err();
    test_timeout();
    test_back_to_back();
    test_reset_mid_frame();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
